// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit in EX: iterative shift-add multiply and restoring divide; FAST_MUL_EN selects a single-cycle multiplier.
// Latency: DW+2 cycles per op (valid in cycle DW+1); divide-by-zero and signed overflow finish in cycle 1; fast multiplies finish in cycle 0.
// Backpressure: none accepted; stalls the front end through hold_flag_o while an op is in flight.
module ex_muldiv #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   inst_i,
    input  logic [DW-1:0] op1_i,
    input  logic [DW-1:0] op2_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          reg_wen_i,
    output logic [DW-1:0] md_result_o,
    output logic [4:0]    md_rd_addr_o,
    output logic          md_reg_wen_o,
    output logic          md_valid_o,
    output logic          hold_flag_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    acc_q;   // remainder (divide) or product high half (multiply)
    logic [DW-1:0]    lo_q;    // dividend/quotient (divide) or multiplier/product low half
    logic [DW-1:0]    b_q;     // divisor or multiplicand magnitude
    logic [2:0]       f3_q;
    logic             neg_q;
    logic [4:0]       rd_q;
    logic             wen_q;
    logic [DW-1:0]    md_res_q;
    logic [4:0]       md_rd_q;
    logic             md_wen_q;
    logic             md_vld_q;

    logic          unused_inst;
    assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

    logic [2:0]    f3;
    logic          is_mop;
    logic          is_div;
    logic          sgn1_op;
    logic          sgn2_op;
    logic          s1;
    logic          s2;
    logic [DW-1:0] mag1;
    logic [DW-1:0] mag2;
    logic          neg;
    logic          div_zero;
    logic          div_ovf;
    logic [DW-1:0] spec_res;

    assign f3      = inst_i[14:12];
    assign is_mop  = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
    assign is_div  = f3[2];
    assign sgn1_op = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    assign sgn2_op = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    assign s1      = sgn1_op & op1_i[DW-1];
    assign s2      = sgn2_op & op2_i[DW-1];
    assign mag1    = s1 ? -op1_i : op1_i;
    assign mag2    = s2 ? -op2_i : op2_i;
    // Remainder follows the dividend; quotient and product follow the sign XOR.
    assign neg     = (is_div && f3[1]) ? s1 : (s1 ^ s2);

    assign div_zero = is_div && (op2_i == '0);
    assign div_ovf  = ((f3 == F3_DIV) || (f3 == F3_REM)) &&
                      (op1_i == {1'b1, {(DW-1){1'b0}}}) && (op2_i == '1);

    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = f3[1] ? op1_i : '1;
        else if (div_ovf)
            spec_res = f3[1] ? '0 : {1'b1, {(DW-1){1'b0}}};
    end

    logic          fast_op;
    logic          fast_hit;
    logic [DW-1:0] fast_res;

`ifdef FAST_MUL_EN
    logic [DW:0]           fast_a;
    logic [DW:0]           fast_b;
    logic signed [2*DW+1:0] fast_prod;
    logic                  unused_fast;

    assign fast_a      = {s1, op1_i};
    assign fast_b      = {s2, op2_i};
    assign fast_prod   = $signed(fast_a) * $signed(fast_b);
    assign unused_fast = ^fast_prod[2*DW+1:2*DW];
    assign fast_op     = is_mop && !is_div;
    assign fast_hit    = fast_op && (state_q == S_IDLE) && !rst;
    assign fast_res    = (f3 == F3_MUL) ? fast_prod[DW-1:0] : fast_prod[2*DW-1:DW];
`else
    assign fast_op  = 1'b0;
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    logic start;
    assign start = is_mop && !fast_op;

    // One iteration of each algorithm; the op class picks which one advances the registers.
    logic [DW:0]   mul_sum;
    logic [DW:0]   rem_sh;
    logic [DW:0]   diff;
    logic          q_bit;
    logic [DW-1:0] acc_n;
    logic [DW-1:0] lo_n;

    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rem_sh  = {acc_q, lo_q[DW-1]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign q_bit   = !diff[DW];

    always_comb begin
        acc_n = mul_sum[DW:1];
        lo_n  = {mul_sum[0], lo_q[DW-1:1]};
        if (f3_q[2]) begin
            acc_n = q_bit ? diff[DW-1:0] : rem_sh[DW-1:0];
            lo_n  = {lo_q[DW-2:0], q_bit};
        end
    end

    logic [2*DW-1:0] prod_n;
    logic [2*DW-1:0] prod_s;
    logic [DW-1:0]   div_r;
    logic [DW-1:0]   fin_res;

    assign prod_n = {acc_n, lo_n};
    assign prod_s = neg_q ? -prod_n : prod_n;
    assign div_r  = f3_q[1] ? acc_n : lo_n;

    always_comb begin
        fin_res = '0;
        if (f3_q[2])
            fin_res = neg_q ? -div_r : div_r;
        else if (f3_q == F3_MUL)
            fin_res = prod_s[DW-1:0];
        else
            fin_res = prod_s[2*DW-1:DW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            wen_q    <= 1'b0;
            md_res_q <= '0;
            md_rd_q  <= '0;
            md_wen_q <= 1'b0;
            md_vld_q <= 1'b0;
        end else begin
            md_res_q <= '0;
            md_rd_q  <= '0;
            md_wen_q <= 1'b0;
            md_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        f3_q  <= f3;
                        neg_q <= neg;
                        rd_q  <= rd_addr_i;
                        wen_q <= reg_wen_i;
                        cnt_q <= '0;
                        acc_q <= '0;
                        lo_q  <= mag1;
                        b_q   <= mag2;
                        if (div_zero || div_ovf) begin
                            state_q  <= S_DONE;
                            md_res_q <= spec_res;
                            md_rd_q  <= rd_addr_i;
                            md_wen_q <= reg_wen_i;
                            md_vld_q <= 1'b1;
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DW-1)) begin
                        state_q  <= S_DONE;
                        md_res_q <= fin_res;
                        md_rd_q  <= rd_q;
                        md_wen_q <= wen_q;
                        md_vld_q <= 1'b1;
                    end
                end
                default: begin
                    // The held M-op still visible on inst_i here is deliberately not restarted.
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hold_flag_o  = !rst && (((state_q == S_IDLE) && start) || (state_q == S_BUSY));
    assign md_valid_o   = fast_hit | md_vld_q;
    assign md_result_o  = fast_hit ? fast_res  : md_res_q;
    assign md_rd_addr_o = fast_hit ? rd_addr_i : md_rd_q;
    assign md_reg_wen_o = fast_hit ? reg_wen_i : md_wen_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, hold profile, results, rd/wen echo, reset abort, back-to-back ops.
module tb_ex_muldiv;

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wen_i;
    logic [31:0] md_result_o;
    logic [4:0]  md_rd_addr_o;
    logic        md_reg_wen_o;
    logic        md_valid_o;
    logic        hold_flag_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_g  = 0;

    ex_muldiv #(.DW(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .rd_addr_i    (rd_addr_i),
        .reg_wen_i    (reg_wen_i),
        .md_result_o  (md_result_o),
        .md_rd_addr_o (md_rd_addr_o),
        .md_reg_wen_o (md_reg_wen_o),
        .md_valid_o   (md_valid_o),
        .hold_flag_o  (hold_flag_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; presents one M-op as cycle 0 and follows it until md_valid_o.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic wen,
                          input logic [31:0] exp, input int exp_lat, output int vabs);
        int vcyc;
        int holds;
        logic [31:0] r;
        logic [4:0]  ra;
        logic        w;
        vcyc  = -1;
        holds = 0;
        vabs  = -1;
        r     = '0;
        ra    = '0;
        w     = 1'b0;
        inst_i    = {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
        op1_i     = a;
        op2_i     = b;
        rd_addr_i = rd;
        reg_wen_i = wen;
        for (int c = 0; c < 40 && vcyc < 0; c++) begin
            @(negedge clk);
            if (hold_flag_o) holds++;
            if (md_valid_o) begin
                vcyc = c;
                vabs = cyc_g;
                r    = md_result_o;
                ra   = md_rd_addr_o;
                w    = md_reg_wen_o;
            end
            @(posedge clk);
            #1;
        end
        inst_i = NOP;
        chk({tag, "_lat"},   vcyc,  exp_lat);
        chk({tag, "_holds"}, holds, exp_lat);
        chk({tag, "_res"},   r,     exp);
        chk({tag, "_rd"},    {27'd0, ra}, {27'd0, rd});
        chk({tag, "_wen"},   {31'd0, w},  {31'd0, wen});
    endtask

    initial begin
        int v1;
        int v2;
        int vcnt;
        rst       = 1'b1;
        inst_i    = NOP;
        op1_i     = '0;
        op2_i     = '0;
        rd_addr_i = '0;
        reg_wen_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res",   md_result_o,  32'h0);
        chk("rst_rd",    {27'd0, md_rd_addr_o}, 32'h0);
        chk("rst_wen",   {31'd0, md_reg_wen_o}, 32'h0);
        chk("rst_valid", {31'd0, md_valid_o},   32'h0);
        chk("rst_hold",  {31'd0, hold_flag_o},  32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_hold",  {31'd0, hold_flag_o}, 32'h0);
        chk("idle_valid", {31'd0, md_valid_o},  32'h0);
        @(posedge clk);
        #1;

        run_op("divu_100_7",  3'b101, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14, 33, v1);
        run_op("remu_100_7",  3'b111, 32'd100, 32'd7, 5'd4, 1'b1, 32'd2,  33, v1);
        run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd17, 1'b1, 32'hFFFF_FFFD, 33, v1);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd0,  1'b0, 32'hFFFF_FFFF, 33, v1);
        run_op("div_20_m3",   3'b100, 32'd20, 32'hFFFF_FFFD, 5'd9, 1'b1, 32'hFFFF_FFFA, 33, v1);
        run_op("rem_20_m3",   3'b110, 32'd20, 32'hFFFF_FFFD, 5'd9, 1'b1, 32'd2, 33, v1);

        run_op("divu_5_0",    3'b101, 32'd5, 32'd0, 5'd5, 1'b1, 32'hFFFF_FFFF, 1, v1);
        run_op("remu_5_0",    3'b111, 32'd5, 32'd0, 5'd6, 1'b1, 32'd5, 1, v1);
        run_op("rem_m5_0",    3'b110, 32'hFFFF_FFFB, 32'd0, 5'd7, 1'b0, 32'hFFFF_FFFB, 1, v1);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'h8000_0000, 1, v1);
        run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'h0, 1, v1);

        run_op("mul_m1_m1",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h1, MUL_LAT, v1);
        run_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'hFFFF_FFFE, MUL_LAT, v1);
        run_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd12, 1'b1, 32'h4000_0000, MUL_LAT, v1);
        run_op("mulhsu_m1",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1'b0, 32'hFFFF_FFFF, MUL_LAT, v1);
        run_op("mul_1234_m5", 3'b000, 32'd1234, 32'hFFFF_FFFB, 5'd14, 1'b1, 32'hFFFF_E7E6, MUL_LAT, v1);

        // Reset lands in cycle 10 of a divide; the partial result must never surface.
        inst_i    = {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd15, 7'b0110011};
        op1_i     = 32'd1000;
        op2_i     = 32'd3;
        rd_addr_i = 5'd15;
        reg_wen_i = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst    = 1'b1;
        inst_i = NOP;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_hold",  {31'd0, hold_flag_o}, 32'h0);
        chk("abort_valid", {31'd0, md_valid_o},  32'h0);
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_valid_o || hold_flag_o) vcnt++;
        end
        chk("abort_quiet", vcnt, 32'd0);
        @(posedge clk);
        #1;

        run_op("b2b_div_a", 3'b100, 32'd1000, 32'd10, 5'd20, 1'b1, 32'd100, 33, v1);
        run_op("b2b_div_b", 3'b100, 32'hFFFF_FC18, 32'd10, 5'd21, 1'b1, 32'hFFFF_FF9C, 33, v2);
        chk("b2b_spacing", v2 - v1, 32'd34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
